mem_window_checker: RTL and testbench
=====================================

# mem_window_checker

Parametrised, synthesizable memory-write monitor and ordering checker for the pipelined RISC-V core's data-memory port. Snoops the MEM-stage store bus, shadows every aligned word store that falls inside a configurable address window, and, on request, scans the shadow copy to verify ascending or descending order. Sits beside the data memory in the CPU top level. It replaces ad-hoc console monitoring with a hardware pass/fail result that a bench or on-chip status register can read.

## Interface
Parameters:
- `ADDR_W`, 32, store address width
- `DATA_W`, 32, store data width; word = DATA_W/8 bytes
- `BASE_ADDR`, 32'h200, first byte address of the window; must be word aligned
- `NUM_WORDS`, 10, window depth in words; must be ≥ 2
- `SIGNED_CMP`, 0, 1 = compare as two's complement, 0 = unsigned

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_en`  in  1  store valid (MemWrite_M)
- `wr_addr`  in  ADDR_W  store byte address (res_M)
- `wr_data`  in  DATA_W  store data (WriteData_M)
- `clear`  in  1  discard shadow contents and results
- `start_check`  in  1  request a scan
- `order_desc`  in  1  0 = non-decreasing, 1 = non-increasing; sampled with start_check
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse when a result is ready
- `pass`  out  1  last scan succeeded; held
- `fail_code`  out  3  0 none, 1 order violation, 2 unwritten slot, 3 misaligned store, 4 store during scan
- `fail_index`  out  $clog2(NUM_WORDS)  slot index for codes 1/2, else 0
- `write_count`  out  16  in-window aligned stores captured; saturates at 16'hFFFF

## Operation
- In window means BASE_ADDR ≤ wr_addr < BASE_ADDR + 4·NUM_WORDS. Out-of-window stores are ignored entirely.
- Aligned in-window store while not busy:
  - shadow[(wr_addr−BASE_ADDR)>>2] ← wr_data
  - valid bit set
  - write_count increments
  - later stores overwrite earlier ones.
- Misaligned in-window store (wr_addr[1:0]≠0): not captured; sets sticky `misaligned` flag.
- In-window store while busy: not captured; sets sticky `late` flag.
- FSM states:
  - **IDLE**: start_check goes to SCAN, latches order_desc, sets i=0.
  - **SCAN**: each cycle checks pair (i, i+1).
    - !valid[i] gives code 2, index i. Otherwise !valid[i+1] gives code 2, index i+1.
    - Else an order violation gives code 1, index i. Equal values are legal.
    - First failure goes to DONE.
    - Otherwise i++; when i = NUM_WORDS−2 and the pair passes, go to DONE.
  - **DONE**: done pulses high for the entry cycle only; state returns to IDLE on the following cycle.
- Final code priority: misaligned (3) > late (4) > scan result (2/1) > 0. Index is forced to 0 for codes 3/4. pass = (fail_code==0).
- start_check while busy is ignored.
- clear in any state:
  - state → IDLE
  - valid bits, flags, write_count and results zeroed
  - a store in the same cycle as clear is discarded.
- Reset: identical to clear. All outputs 0 (busy, done, pass, fail_code, fail_index, write_count).

## Timing
- A store sampled at edge t is visible to a scan started at t; start_check and store in the same cycle means the store is captured first.
- start_check sampled at edge t: busy=1 from t+1.
- Full pass: done=1 in cycle t+NUM_WORDS. busy covers t+1 … t+NUM_WORDS−1, i.e. NUM_WORDS−1 scan cycles.
- Early failure at pair i: done in cycle t+i+2.
- busy=0 whenever done=1.
- pass, fail_code and fail_index update in the done cycle and hold until the next done, clear or rst.
- Sticky flags persist across scans until clear or rst.

## Structure
- Shared package `mwc_pkg`:
  - fail_code enum (FAIL_NONE, FAIL_ORDER, FAIL_UNWRITTEN, FAIL_MISALIGNED, FAIL_LATE)
  - FSM state enum
- Sub-module `mwc_cmp`: combinational DATA_W comparator.
  - Inputs: a, b, desc, signed-mode parameter.
  - Output: `ok`.
- Shadow storage is a register array with a valid vector; no RAM macro.

## Test plan
- Store 9,8,…,0 to 0x200…0x224, start_check with order_desc=1. Expect:
  - done 10 cycles after start
  - pass=1, fail_code=0, write_count=10.
- Same data, order_desc=0 → pass=0, fail_code=1, fail_index=0, done 2 cycles after start.
- Store 0..9 ascending but skip 0x214 → fail_code=2, fail_index=5. Repeat with SIGNED_CMP=1 and values −5…4 ascending → pass=1.
- Out-of-window and misaligned stores:
  - store to 0x300 and 0x1FC → ignored, write_count unchanged
  - store to 0x202 → final fail_code=3 even if the order is correct.
- Store to 0x208 during SCAN → shadow unchanged, fail_code=4. Then clear → all outputs 0; rescan reports code 2 at index 0.
- Assert rst mid-scan (cycle 3 of SCAN) → next cycle busy=0, done=0, write_count=0; a subsequent start_check reports fail_code=2, fail_index=0.

Source files
------------

// File: rtl/mwc_pkg.sv
// Shared types for the memory-window ordering checker.
package mwc_pkg;

  typedef enum logic [2:0] {
    FAIL_NONE       = 3'd0,
    FAIL_ORDER      = 3'd1,
    FAIL_UNWRITTEN  = 3'd2,
    FAIL_MISALIGNED = 3'd3,
    FAIL_LATE       = 3'd4
  } fail_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mwc_cmp.sv
// Pairwise order comparator: ok when a may precede b in the requested direction.
module mwc_cmp #(
  parameter int DATA_W     = 32,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              desc,
  output logic              ok
);

  logic a_lt_b;
  logic a_gt_b;

  always_comb begin
    if (SIGNED_CMP) begin
      a_lt_b = $signed(a) < $signed(b);
      a_gt_b = $signed(a) > $signed(b);
    end else begin
      a_lt_b = a < b;
      a_gt_b = a > b;
    end
    // Equal neighbours are legal in both directions.
    ok = desc ? !a_lt_b : !a_gt_b;
  end

endmodule

// File: rtl/mem_window_checker.sv
// Shadows aligned word stores inside an address window and scans the copy
// for ascending/descending order, reporting a held pass/fail result.
//
// state   | meaning
// IDLE    | capturing stores, waiting for start_check
// SCAN    | checking pair (scan_i, scan_i+1) each cycle
// DONE    | one-cycle result strobe, then back to IDLE
module mem_window_checker
  import mwc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h200,
  parameter int                NUM_WORDS  = 10,
  parameter bit                SIGNED_CMP = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         clear,
  input  logic                         start_check,
  input  logic                         order_desc,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [2:0]                   fail_code,
  output logic [$clog2(NUM_WORDS)-1:0] fail_index,
  output logic [15:0]                  write_count
);

  localparam int               IDX_W     = $clog2(NUM_WORDS);
  localparam logic [ADDR_W:0]  WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]  WIN_HI    = WIN_LO + (ADDR_W+1)'(4 * NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_PAIR = IDX_W'(NUM_WORDS - 2);

  state_e              state, state_nxt;
  logic [IDX_W-1:0]    scan_i, i_nxt, i_p1;
  logic                desc_q;
  logic [NUM_WORDS-1:0] valid;
  logic [DATA_W-1:0]   shadow [NUM_WORDS];
  logic                misal, late, misal_n, late_n;

  logic                in_win, aligned, capture, misal_set, late_set;
  logic [IDX_W+1:0]    off;
  logic [IDX_W-1:0]    wr_idx;
  logic                pair_ok, finish;
  fail_code_e          scan_code, final_code;
  logic [IDX_W-1:0]    scan_idx, final_idx;

  // Window base is word aligned, so the low offset bits double as the
  // alignment check and the upper address bits never affect the slot index.
  assign in_win    = wr_en && ({1'b0, wr_addr} >= WIN_LO) && ({1'b0, wr_addr} < WIN_HI);
  assign off       = wr_addr[IDX_W+1:0] - BASE_ADDR[IDX_W+1:0];
  assign wr_idx    = off[IDX_W+1:2];
  assign aligned   = (off[1:0] == 2'b00);
  assign busy      = (state == ST_SCAN);
  assign done      = (state == ST_DONE);
  assign capture   = in_win && aligned && !busy;
  assign misal_set = in_win && !aligned;
  assign late_set  = in_win && busy;
  assign misal_n   = misal || misal_set;
  assign late_n    = late || late_set;
  assign i_p1      = scan_i + IDX_W'(1);

  mwc_cmp #(
    .DATA_W    (DATA_W),
    .SIGNED_CMP(SIGNED_CMP)
  ) u_cmp (
    .a   (shadow[scan_i]),
    .b   (shadow[i_p1]),
    .desc(desc_q),
    .ok  (pair_ok)
  );

  always_ff @(posedge clk) begin
    if (capture && !rst && !clear) shadow[wr_idx] <= wr_data;
  end

  always_comb begin
    state_nxt = state;
    i_nxt     = scan_i;
    finish    = 1'b0;
    scan_code = FAIL_NONE;
    scan_idx  = '0;
    case (state)
      ST_IDLE: begin
        if (start_check) begin
          state_nxt = ST_SCAN;
          i_nxt     = '0;
        end
      end
      ST_SCAN: begin
        if (!valid[scan_i]) begin
          scan_code = FAIL_UNWRITTEN;
          scan_idx  = scan_i;
        end else if (!valid[i_p1]) begin
          scan_code = FAIL_UNWRITTEN;
          scan_idx  = i_p1;
        end else if (!pair_ok) begin
          scan_code = FAIL_ORDER;
          scan_idx  = scan_i;
        end
        if (scan_code != FAIL_NONE || scan_i == LAST_PAIR) begin
          state_nxt = ST_DONE;
          finish    = 1'b1;
        end else begin
          i_nxt = i_p1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sticky store faults outrank whatever the scan found.
  always_comb begin
    final_code = scan_code;
    final_idx  = scan_idx;
    if (misal_n) begin
      final_code = FAIL_MISALIGNED;
      final_idx  = '0;
    end else if (late_n) begin
      final_code = FAIL_LATE;
      final_idx  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state       <= ST_IDLE;
      scan_i      <= '0;
      desc_q      <= 1'b0;
      valid       <= '0;
      misal       <= 1'b0;
      late        <= 1'b0;
      write_count <= '0;
      pass        <= 1'b0;
      fail_code   <= FAIL_NONE;
      fail_index  <= '0;
    end else begin
      state  <= state_nxt;
      scan_i <= i_nxt;
      misal  <= misal_n;
      late   <= late_n;
      if (state == ST_IDLE && start_check) desc_q <= order_desc;
      if (capture) begin
        valid[wr_idx] <= 1'b1;
        if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
      end
      if (finish) begin
        fail_code  <= final_code;
        fail_index <= final_idx;
        pass       <= (final_code == FAIL_NONE);
      end
    end
  end

endmodule

// File: tb/tb_mem_window_checker.sv
// Scoreboard bench: unsigned and signed checkers share stimulus; a window
// model predicts each scan result and a negedge monitor compares on done.
module tb_mem_window_checker;

  localparam int          N    = 10;
  localparam logic [31:0] BASE = 32'h200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, clear = 1'b0, start_check = 1'b0, order_desc = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0;

  logic        busy_u, done_u, pass_u, busy_s, done_s, pass_s;
  logic [2:0]  code_u, code_s;
  logic [3:0]  idx_u, idx_s;
  logic [15:0] wc_u, wc_s;

  mem_window_checker #(.SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .start_check(start_check), .order_desc(order_desc),
    .busy(busy_u), .done(done_u), .pass(pass_u), .fail_code(code_u),
    .fail_index(idx_u), .write_count(wc_u));

  mem_window_checker #(.SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .start_check(start_check), .order_desc(order_desc),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail_code(code_s),
    .fail_index(idx_s), .write_count(wc_s));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_mem [N];
  bit          m_vld [N];
  bit          m_mis, m_late;
  int          m_wc;

  typedef struct {
    int edge_n;
    int code;
    int idx;
    int wc;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];

  function automatic void m_clear();
    for (int k = 0; k < N; k++) m_vld[k] = 1'b0;
    m_mis = 1'b0; m_late = 1'b0; m_wc = 0;
  endfunction

  function automatic void m_store(logic [31:0] a, logic [31:0] d);
    if (a >= BASE && a < BASE + 4 * N) begin
      if (a[1:0] != 2'b00) m_mis = 1'b1;
      else begin
        m_mem[int'((a - BASE) >> 2)] = d;
        m_vld[int'((a - BASE) >> 2)] = 1'b1;
        if (m_wc < 65535) m_wc++;
      end
    end
  endfunction

  function automatic bit out_of_order(bit sgn, bit desc, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    if (sgn) return desc ? (sa < sb) : (sa > sb);
    return desc ? (a < b) : (a > b);
  endfunction

  function automatic exp_t predict(bit sgn, bit desc, int t);
    exp_t e;
    int   fp = -1;
    e.code = 0; e.idx = 0; e.wc = m_wc;
    for (int p = 0; p < N - 1; p++) begin
      if (!m_vld[p])          begin e.code = 2; e.idx = p;     fp = p; break; end
      if (!m_vld[p + 1])      begin e.code = 2; e.idx = p + 1; fp = p; break; end
      if (out_of_order(sgn, desc, m_mem[p], m_mem[p + 1]))
                              begin e.code = 1; e.idx = p;     fp = p; break; end
    end
    e.edge_n = (fp < 0) ? t + N - 1 : t + fp + 1;
    if (m_mis)       begin e.code = 3; e.idx = 0; end
    else if (m_late) begin e.code = 4; e.idx = 0; end
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (done_u) begin
      if (q_u.size() == 0) chk("unexpected_done_u", 1, 0);
      else begin
        e = q_u.pop_front();
        chk("done_cycle_u", cyc, e.edge_n);
        chk("fail_code_u", code_u, e.code);
        chk("fail_index_u", idx_u, e.idx);
        chk("pass_u", pass_u, (e.code == 0));
        chk("write_count_u", wc_u, e.wc);
        chk("busy_at_done_u", busy_u, 0);
      end
    end
    if (done_s) begin
      if (q_s.size() == 0) chk("unexpected_done_s", 1, 0);
      else begin
        e = q_s.pop_front();
        chk("done_cycle_s", cyc, e.edge_n);
        chk("fail_code_s", code_s, e.code);
        chk("fail_index_s", idx_s, e.idx);
        chk("pass_s", pass_s, (e.code == 0));
        chk("write_count_s", wc_s, e.wc);
        chk("busy_at_done_s", busy_s, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit we, logic [31:0] a, logic [31:0] d, bit clr, bit st, bit ds);
    @(negedge clk);
    wr_en = we; wr_addr = a; wr_data = d; clear = clr; start_check = st; order_desc = ds;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    drive(1'b1, a, d, 1'b0, 1'b0, 1'b0);
    m_store(a, d);
  endtask

  task automatic check_zero(string tag);
    chk({"busy_", tag}, {busy_u, busy_s}, 0);
    chk({"done_", tag}, {done_u, done_s}, 0);
    chk({"pass_", tag}, {pass_u, pass_s}, 0);
    chk({"fail_code_", tag}, {code_u, code_s}, 0);
    chk({"fail_index_", tag}, {idx_u, idx_s}, 0);
    chk({"write_count_", tag}, {wc_u, wc_s}, 0);
  endtask

  task automatic do_clear(bit verify);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    m_clear();
    idle();
    if (verify) check_zero("after_clear");
  endtask

  // extra: 0 nothing, 1 in-window store during scan, 2 start_check during scan
  task automatic run_scan(bit desc, int extra);
    int t;
    drive(1'b0, '0, '0, 1'b0, 1'b1, desc);
    t = cyc + 1;
    if (extra == 1) m_late = 1'b1;
    q_u.push_back(predict(1'b0, desc, t));
    q_s.push_back(predict(1'b1, desc, t));
    if (extra == 1)      drive(1'b1, BASE + 8, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    else if (extra == 2) drive(1'b0, '0, '0, 1'b0, 1'b1, ~desc);
    else                 idle();
    chk("busy_after_start", {busy_u, busy_s}, 2'b11);
    for (int k = 0; k < 40 && (q_u.size() != 0 || q_s.size() != 0); k++) idle();
    chk("scan_timeout_pending", q_u.size() + q_s.size(), 0);
    q_u.delete(); q_s.delete();
    idle(); idle();
  endtask

  task automatic fill_ascending();
    for (int i = 0; i < N; i++) store(BASE + 4 * i, 32'(i));
  endtask

  initial begin
    logic [31:0] v;
    int          mode;
    m_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // descending data, both directions
    for (int i = 0; i < N; i++) store(BASE + 4 * i, 32'(9 - i));
    run_scan(1'b1, 0);
    run_scan(1'b0, 0);

    // hole at 0x214
    do_clear(1'b0);
    for (int i = 0; i < N; i++) if (i != 5) store(BASE + 4 * i, 32'(i));
    run_scan(1'b0, 0);

    // -5..4: ordered only when compared as signed
    do_clear(1'b0);
    for (int i = 0; i < N; i++) store(BASE + 4 * i, 32'(i - 5));
    run_scan(1'b0, 0);

    // out-of-window stores are invisible, misaligned one is sticky
    store(32'h300, 32'h55);
    store(32'h1FC, 32'h66);
    idle();
    chk("wc_out_of_window_u", wc_u, 10);
    chk("wc_out_of_window_s", wc_s, 10);
    store(32'h202, 32'h77);
    run_scan(1'b0, 0);

    // store during scan, then clear and rescan an empty window
    do_clear(1'b0);
    fill_ascending();
    run_scan(1'b0, 1);
    do_clear(1'b1);
    run_scan(1'b0, 0);

    // reset in the third scan cycle
    fill_ascending();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(); idle();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_clear();
    check_zero("rst_mid_scan");
    run_scan(1'b0, 0);

    // randomized windows
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) != 0) do_clear(1'b0);
      mode = $urandom_range(0, 3);
      v = $urandom;
      case (mode)
        0: for (int i = 0; i < N; i++) begin store(BASE + 4 * i, v); v = v + $urandom_range(0, 3); end
        1: for (int i = 0; i < N; i++) begin store(BASE + 4 * i, v); v = v - $urandom_range(0, 3); end
        2: repeat ($urandom_range(5, 25)) store(BASE + 4 * $urandom_range(0, N - 1), $urandom);
        default: begin
          for (int i = 0; i < N; i++) begin
            store(BASE + 4 * i, v);
            v = v + $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0)
              store($urandom_range(0, 1) ? BASE - 4 * $urandom_range(1, 8)
                                         : BASE + 4 * N + 4 * $urandom_range(0, 8), $urandom);
          end
          if ($urandom_range(0, 7) == 0)
            store(BASE + 4 * $urandom_range(0, N - 1) + $urandom_range(1, 3), $urandom);
        end
      endcase
      run_scan(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0 ? 1 :
                                         ($urandom_range(0, 4) == 0 ? 2 : 0));
    end

    repeat (3) idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
